// File: rtl/out_channel_pkg.sv
// Shared types and width helpers for the out-channel drain stage.
package out_channel_pkg;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DONE
   } drainStateT;

   localparam int DefaultWidth = 12;
   localparam int DefaultNOut  = 100;

   // Pointer width for a buffer of n words (at least 1 bit).
   function automatic int ptrWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width able to hold the values 0..n.
   function automatic int cntWidth(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/out_ring.sv
// Circular buffer with overwrite-on-full for the out channel.
module out_ring
   import out_channel_pkg::*;
#(
   parameter int MemoryElementWidth = DefaultWidth,
   parameter int NOut               = DefaultNOut,
   localparam int PtrW              = ptrWidth(NOut),
   localparam int CntW              = cntWidth(NOut)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wrEn,
   input  logic [MemoryElementWidth-1:0] wrData,
   input  logic                          rdEn,
   output logic [MemoryElementWidth-1:0] rdData,
   output logic [CntW-1:0]               count,
   output logic                          empty,
   output logic                          full,
   output logic                          overwrite
);

   localparam logic [PtrW-1:0] LastPtr = PtrW'(NOut - 1);

   logic [MemoryElementWidth-1:0] mem [NOut];
   logic [PtrW-1:0]               wr;
   logic [PtrW-1:0]               rd;
   logic                          rdGo;

   function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   assign empty  = (count == '0);
   assign full   = (count == CntW'(NOut));
   assign rdGo   = rdEn && !empty;
   // A full write with no read drops the oldest word; a read in the same cycle frees the slot instead.
   assign overwrite = wrEn && full && !rdGo;
   assign rdData = mem[rd];

   // Pointer and occupancy tracking.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (wrEn) wr <= nextPtr(wr);
         if (rdGo || overwrite) rd <= nextPtr(rd);
         if (wrEn && !rdGo && !full) count <= count + CntW'(1);
         else if (rdGo && !wrEn)     count <= count - CntW'(1);
      end
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (wrEn) mem[wr] <= wrData;
   end

endmodule

// File: rtl/out_channel_drain.sv
// Captures out-instruction values and streams them to a consumer, flushing on finish.
module out_channel_drain
   import out_channel_pkg::*;
#(
   parameter int MemoryElementWidth = DefaultWidth,
   parameter int NOut               = DefaultNOut
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          outValid,
   input  logic [MemoryElementWidth-1:0] outData,
   input  logic                          finished,
   output logic                          drainValid,
   output logic [MemoryElementWidth-1:0] drainData,
   input  logic                          drainReady,
   output logic [cntWidth(NOut)-1:0]     count,
   output logic                          overflow,
   output logic                          lateWrite,
   output logic                          drained
);

   localparam int CntW = cntWidth(NOut);

   drainStateT stateQ;
   drainStateT stateD;
   logic       wrEn;
   logic       rdGo;
   logic       empty;
   logic       full;
   logic       overwrite;
   logic       willEmpty;

   assign wrEn       = outValid && (stateQ == RUN);
   assign drainValid = !empty;
   assign rdGo       = drainValid && drainReady;
   assign drained    = (stateQ == DONE);
   // Occupancy after this edge is zero: lets DONE be reached on the same edge as the last read.
   assign willEmpty  = !wrEn && ((count == '0) || ((count == CntW'(1)) && rdGo));

   out_ring #(
      .MemoryElementWidth(MemoryElementWidth),
      .NOut              (NOut)
   ) ring (
      .clock    (clock),
      .reset    (reset),
      .wrEn     (wrEn),
      .wrData   (outData),
      .rdEn     (rdGo),
      .rdData   (drainData),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .overwrite(overwrite)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) stateQ <= RUN;
      else        stateQ <= stateD;
   end

   // Next-state logic for RUN -> FLUSH -> DONE.
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         RUN:     if (finished) stateD = willEmpty ? DONE : FLUSH;
         FLUSH:   if (willEmpty) stateD = DONE;
         DONE:    stateD = DONE;
         default: stateD = RUN;
      endcase
   end

   // Sticky error flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         lateWrite <= 1'b0;
      end else begin
         if (overwrite) overflow <= 1'b1;
         if (outValid && (stateQ != RUN)) lateWrite <= 1'b1;
      end
   end

endmodule

// File: tb/tb_out_channel_drain.sv
// Scoreboard bench for out_channel_drain using a 4-word buffer.
module tb_out_channel_drain;

   localparam int W    = 12;
   localparam int NOut = 4;
   localparam int CntW = $clog2(NOut + 1);

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            outValid = 1'b0;
   logic [W-1:0]    outData = '0;
   logic            finished = 1'b0;
   logic            drainValid;
   logic [W-1:0]    drainData;
   logic            drainReady = 1'b0;
   logic [CntW-1:0] count;
   logic            overflow;
   logic            lateWrite;
   logic            drained;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [W-1:0] expQ[$];
   logic [W-1:0] gotQ[$];
   logic         accepting = 1'b1;
   logic         expOverflow = 1'b0;
   logic         expLate = 1'b0;
   logic         expDrained = 1'b0;

   out_channel_drain #(
      .MemoryElementWidth(W),
      .NOut              (NOut)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .outValid  (outValid),
      .outData   (outData),
      .finished  (finished),
      .drainValid(drainValid),
      .drainData (drainData),
      .drainReady(drainReady),
      .count     (count),
      .overflow  (overflow),
      .lateWrite (lateWrite),
      .drained   (drained)
   );

   always #5 clock = ~clock;

   // One clock cycle: check state at the falling edge, update the model, advance past the rising edge.
   task automatic cycle();
      logic         rd;
      logic [W-1:0] e;
      @(negedge clock);
      tests++;
      if (drainValid !== (expQ.size() != 0)) begin
         fails++; $display("FAIL drainValid: got %b want %b", drainValid, expQ.size() != 0);
      end
      tests++;
      if (count !== CntW'(expQ.size())) begin
         fails++; $display("FAIL count: got %0d want %0d", count, expQ.size());
      end
      tests++;
      if (overflow !== expOverflow || lateWrite !== expLate || drained !== expDrained) begin
         fails++;
         $display("FAIL flags: got ovf=%b late=%b drained=%b want ovf=%b late=%b drained=%b",
                  overflow, lateWrite, drained, expOverflow, expLate, expDrained);
      end
      rd = drainValid && drainReady;
      if (rd) begin
         tests++;
         if (expQ.size() == 0) begin
            fails++; $display("FAIL unexpected read: got %0d want none", drainData);
         end else begin
            e = expQ.pop_front();
            gotQ.push_back(drainData);
            if (drainData !== e) begin
               fails++; $display("FAIL drainData: got %0d want %0d", drainData, e);
            end
         end
      end
      if (outValid) begin
         if (accepting) begin
            if (expQ.size() == NOut && !rd) begin
               void'(expQ.pop_front());
               expOverflow = 1'b1;
            end
            expQ.push_back(outData);
         end else begin
            expLate = 1'b1;
         end
      end
      if (finished) accepting = 1'b0;
      if (!accepting && expQ.size() == 0) expDrained = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic modelReset();
      expQ.delete();
      gotQ.delete();
      accepting   = 1'b1;
      expOverflow = 1'b0;
      expLate     = 1'b0;
      expDrained  = 1'b0;
   endtask

   task automatic doReset();
      outValid   = 1'b0;
      finished   = 1'b0;
      drainReady = 1'b0;
      reset      = 1'b0;
      modelReset();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic writeWord(input logic [W-1:0] v);
      outValid = 1'b1;
      outData  = v;
      cycle();
      outValid = 1'b0;
   endtask

   task automatic drainUntilDone(input int maxCycles);
      for (int i = 0; i < maxCycles && !drained; i++) cycle();
      tests++;
      if (drained !== 1'b1) begin
         fails++; $display("FAIL drain timeout: drained=%b want 1", drained);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      tests++;
      if (drainValid !== 1'b0 || count !== '0 || overflow !== 1'b0 || lateWrite !== 1'b0 || drained !== 1'b0) begin
         fails++;
         $display("FAIL reset values: got v=%b cnt=%0d ovf=%b late=%b drained=%b want all 0",
                  drainValid, count, overflow, lateWrite, drained);
      end
      doReset();
   endtask

   task automatic test_stream();
      logic [W-1:0] want[4] = '{12'd99, 12'd0, 12'd1, 12'd2};
      doReset();
      drainReady = 1'b1;
      for (int i = 0; i < 4; i++) writeWord(want[i]);
      finished = 1'b1;
      drainUntilDone(10);
      tests++;
      if (gotQ.size() != 4 || overflow !== 1'b0) begin
         fails++; $display("FAIL stream: got %0d words ovf=%b want 4 words ovf=0", gotQ.size(), overflow);
      end
      for (int i = 0; i < 4 && i < gotQ.size(); i++) begin
         tests++;
         if (gotQ[i] !== want[i]) begin
            fails++; $display("FAIL stream order[%0d]: got %0d want %0d", i, gotQ[i], want[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      doReset();
      writeWord(12'd99);
      writeWord(12'd5);
      writeWord(12'd6);
      writeWord(12'd7);
      for (int i = 0; i < 3; i++) begin
         cycle();
         tests++;
         if (drainData !== 12'd99 || count !== CntW'(4)) begin
            fails++; $display("FAIL hold head: got data=%0d cnt=%0d want data=99 cnt=4", drainData, count);
         end
      end
      drainReady = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      cycle();
      tests++;
      if (gotQ.size() != 4 || count !== '0) begin
         fails++; $display("FAIL backpressure drain: got %0d words cnt=%0d want 4 words cnt=0", gotQ.size(), count);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] want[4] = '{12'd12, 12'd13, 12'd14, 12'd15};
      doReset();
      for (int v = 10; v <= 15; v++) writeWord(W'(v));
      cycle();
      tests++;
      if (overflow !== 1'b1 || count !== CntW'(4) || drainData !== 12'd12) begin
         fails++; $display("FAIL overflow state: got ovf=%b cnt=%0d head=%0d want ovf=1 cnt=4 head=12",
                           overflow, count, drainData);
      end
      drainReady = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= gotQ.size() || gotQ[i] !== want[i]) begin
            fails++; $display("FAIL overflow drain[%0d]: got %0d want %0d", i,
                              (i < gotQ.size()) ? gotQ[i] : 'x, want[i]);
         end
      end
   endtask

   task automatic test_full_read();
      doReset();
      for (int v = 20; v < 24; v++) writeWord(W'(v));
      drainReady = 1'b1;
      writeWord(12'd24);
      drainReady = 1'b0;
      cycle();
      tests++;
      if (overflow !== 1'b0 || count !== CntW'(4) || drainData !== 12'd21) begin
         fails++; $display("FAIL full+read: got ovf=%b cnt=%0d head=%0d want ovf=0 cnt=4 head=21",
                           overflow, count, drainData);
      end
   endtask

   task automatic test_late_write();
      doReset();
      writeWord(12'd31);
      writeWord(12'd32);
      writeWord(12'd33);
      finished = 1'b1;
      cycle();
      writeWord(12'd55);
      cycle();
      tests++;
      if (lateWrite !== 1'b1 || count !== CntW'(3)) begin
         fails++; $display("FAIL late write: got late=%b cnt=%0d want late=1 cnt=3", lateWrite, count);
      end
      drainReady = 1'b1;
      drainUntilDone(10);
      tests++;
      if (gotQ.size() != 3 || gotQ[gotQ.size()-1] !== 12'd33) begin
         fails++; $display("FAIL late drain: got %0d words want 3 ending in 33", gotQ.size());
      end
   endtask

   task automatic test_reset_flush();
      doReset();
      writeWord(12'd41);
      writeWord(12'd42);
      finished = 1'b1;
      cycle();
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if (drainValid !== 1'b0 || count !== '0 || overflow !== 1'b0 || lateWrite !== 1'b0 || drained !== 1'b0) begin
         fails++;
         $display("FAIL async reset: got v=%b cnt=%0d ovf=%b late=%b drained=%b want all 0",
                  drainValid, count, overflow, lateWrite, drained);
      end
      finished = 1'b0;
      modelReset();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      drainReady = 1'b1;
      writeWord(12'd7);
      cycle();
      cycle();
      tests++;
      if (gotQ.size() != 1 || gotQ[0] !== 12'd7) begin
         fails++; $display("FAIL post-reset stream: got %0d words want single 7", gotQ.size());
      end
   endtask

   task automatic test_empty_finish();
      doReset();
      drainReady = 1'b1;
      finished = 1'b1;
      cycle();
      tests++;
      if (drained !== 1'b1 || drainValid !== 1'b0) begin
         fails++; $display("FAIL empty finish: got drained=%b valid=%b want drained=1 valid=0", drained, drainValid);
      end
      cycle();
      cycle();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_overflow();
      test_full_read();
      test_late_write();
      test_reset_flush();
      test_empty_finish();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
